// File: rtl/vga_scan_ctrl_if.sv
// Scan-side signal bundle for vga_scan_ctrl: scan enable in, framebuffer
// address / position / pulses and delayed sync/blank out.
interface vga_scan_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              iEN;
  logic [ADDR_W-1:0] oADDR;
  logic              oADDR_VALID;
  logic [10:0]       oX;
  logic [10:0]       oY;
  logic              oFRAME_START;
  logic              oLINE_START;
  logic              oHS;
  logic              oVS;
  logic              oBLANK_n;

  // Scan controller side
  modport master (
    input  iEN,
    output oADDR, oADDR_VALID, oX, oY, oFRAME_START, oLINE_START,
    output oHS, oVS, oBLANK_n
  );

  // Consumer side (memory / video output path)
  modport slave (
    output iEN,
    input  oADDR, oADDR_VALID, oX, oY, oFRAME_START, oLINE_START,
    input  oHS, oVS, oBLANK_n
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: walks h/v counters through active, porch and
// sync regions, produces an incrementally generated framebuffer address with
// optional pixel/line replication, and delays sync/blank by PIPE clocks so
// they line up with the data returned by the downstream memories.
module vga_scan_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int PIPE        = 2,
  parameter int ADDR_W      = 19
) (
  input  logic             iVGA_CLK,
  input  logic             iRST,
  vga_scan_ctrl_if.master  bus
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_CW       = $clog2(H_TOTAL);
  localparam int V_CW       = $clog2(V_TOTAL);
  localparam int HS_BEG     = H_ACTIVE + H_FP;
  localparam int HS_END     = HS_BEG + H_SYNC;
  localparam int VS_BEG     = V_ACTIVE + V_FP;
  localparam int VS_END     = VS_BEG + V_SYNC;
  localparam int ROW_STEP   = H_ACTIVE >> SCALE_SHIFT;
  localparam int SCALE_MASK = (1 << SCALE_SHIFT) - 1;
  // Delay-line word is {blank_n, hs, vs}; idle value is blanked, sync negated.
  localparam logic [2:0] RST_TAP = {1'b0, ~SYNC_POL, ~SYNC_POL};

  // Reject configurations the address generator cannot represent.
  if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_h
    $error("vga_scan_ctrl: H_ACTIVE not divisible by 2**SCALE_SHIFT");
  end
  if ((V_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_v
    $error("vga_scan_ctrl: V_ACTIVE not divisible by 2**SCALE_SHIFT");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 2) begin : g_bad_scale
    $error("vga_scan_ctrl: SCALE_SHIFT must be 0..2");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
    $error("vga_scan_ctrl: PIPE must be 0..7");
  end

  logic [H_CW-1:0]   h_q, h_d;
  logic [V_CW-1:0]   v_q, v_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [10:0]       x_q, x_d;
  logic [10:0]       y_q, y_d;
  logic              fs_q, fs_d;
  logic              ls_q, ls_d;
  logic              hs0_q, hs0_d;
  logic              vs0_q, vs0_d;

  logic              vis;
  logic              h_last;
  logic              v_last;
  logic              v_row_end;
  logic              hs_on;
  logic              vs_on;
  logic [2:0]        stage0;
  logic [2:0]        tap;

  // Decode the current raster position.
  always_comb begin
    vis       = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    h_last    = (int'(h_q) == H_TOTAL - 1);
    v_last    = (int'(v_q) == V_TOTAL - 1);
    v_row_end = ((int'(v_q) & SCALE_MASK) == SCALE_MASK);
    hs_on     = (int'(h_q) >= HS_BEG) && (int'(h_q) < HS_END);
    vs_on     = (int'(v_q) >= VS_BEG) && (int'(v_q) < VS_END);
  end

  // Advance h/v and the base address of the current replicated row.
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    row_base_d = row_base_q;
    if (!bus.iEN) begin
      h_d        = '0;
      v_d        = '0;
      row_base_d = '0;
    end else if (h_last) begin
      h_d = '0;
      if (v_last) begin
        v_d        = '0;
        row_base_d = '0;
      end else begin
        v_d = v_q + V_CW'(1);
        // Only move to the next framebuffer row after 2^s source lines.
        if (v_row_end) begin
          row_base_d = row_base_q + ADDR_W'(ROW_STEP);
        end
      end
    end else begin
      h_d = h_q + H_CW'(1);
    end
  end

  // Registered address/position/pulse outputs describing the current position.
  always_comb begin
    addr_d  = addr_q;
    valid_d = 1'b0;
    x_d     = '0;
    y_d     = '0;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    hs0_d   = ~SYNC_POL;
    vs0_d   = ~SYNC_POL;
    if (!bus.iEN) begin
      addr_d = '0;
    end else begin
      if (vis) begin
        addr_d  = row_base_q + ADDR_W'(h_q >> SCALE_SHIFT);
        valid_d = 1'b1;
        x_d     = 11'(h_q);
        y_d     = 11'(v_q);
        ls_d    = (h_q == '0);
        fs_d    = (h_q == '0) && (v_q == '0);
      end
      hs0_d = hs_on ? SYNC_POL : ~SYNC_POL;
      vs0_d = vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  // State and output registers.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      h_q        <= '0;
      v_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      fs_q       <= 1'b0;
      ls_q       <= 1'b0;
      hs0_q      <= ~SYNC_POL;
      vs0_q      <= ~SYNC_POL;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fs_q       <= fs_d;
      ls_q       <= ls_d;
      hs0_q      <= hs0_d;
      vs0_q      <= vs0_d;
    end
  end

  assign stage0 = {valid_q, hs0_q, vs0_q};

  if (PIPE == 0) begin : g_nopipe
    assign tap = stage0;
  end else begin : g_pipe
    for (genvar gi = 0; gi < PIPE; gi++) begin : g_tap
      logic [2:0] tap_q, tap_d, tap_in;
      if (gi == 0) begin : g_src
        assign tap_in = stage0;
      end else begin : g_src
        assign tap_in = g_tap[gi-1].tap_q;
      end

      // Shift one stage; disabling the scan flushes the line to idle.
      always_comb begin
        tap_d = bus.iEN ? tap_in : RST_TAP;
      end

      // Delay-line register.
      always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
          tap_q <= RST_TAP;
        end else begin
          tap_q <= tap_d;
        end
      end
    end
    assign tap = g_tap[PIPE-1].tap_q;
  end

  assign bus.oADDR        = addr_q;
  assign bus.oADDR_VALID  = valid_q;
  assign bus.oX           = x_q;
  assign bus.oY           = y_q;
  assign bus.oFRAME_START = fs_q;
  assign bus.oLINE_START  = ls_q;
  assign bus.oBLANK_n     = tap[2];
  assign bus.oHS          = tap[1];
  assign bus.oVS          = tap[0];

endmodule
